// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types for the retire buffer.
// retire_rec_t is the record handed to the trace checker; retire_lite_t is the
// stored form used when IBEX_RETIRE_WDATA_EN is undefined (no wdata storage).
package ibex_pkg;

   localparam int unsigned RetireSeqW = 32;

   typedef struct packed {
      logic [RetireSeqW-1:0] seq;
      logic [31:0]           pc;
      logic [31:0]           instr;
      logic [4:0]            rd;
      logic [31:0]           wdata;
      logic                  err;
   } retire_rec_t;

   typedef struct packed {
      logic [RetireSeqW-1:0] seq;
      logic [31:0]           pc;
      logic [31:0]           instr;
      logic [4:0]            rd;
      logic                  err;
   } retire_lite_t;

endpackage

// File: rtl/ibex_retire_fifo.sv
// ibex_retire_fifo: generic synchronous FIFO with push/pop/flush.
// The caller only raises push_i when the entry will be accepted (not full, or
// popping/flushing in the same cycle). A flush discards contents and any
// same-cycle pop; a same-cycle push lands in the freshly cleared FIFO.
module ibex_retire_fifo #(
   parameter int unsigned Width = 32,
   parameter int unsigned Depth = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [Width-1:0]         wdata_i,
   output logic [Width-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(Depth):0]   count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             pop_eff;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign pop_eff = pop_i && !empty_o && !flush_i;

   // Head entry is forced to zero while empty so the output never shows stale data.
   always_comb begin
      rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
   end

   // Next-state: clear or pop first, then append the pushed entry.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else if (pop_eff) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
         count_d  = count_q - CntW'(1);
      end
      if (push_i) begin
         mem_d[wr_ptr_d] = wdata_i;
         wr_ptr_d        = wr_ptr_d + PtrW'(1);
         count_d         = count_d + CntW'(1);
      end
   end

   // Storage and pointer registers, cleared asynchronously.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
      (push_i && full_o) |-> (pop_i || flush_i));

endmodule

// File: rtl/ibex_retire_buffer.sv
// ibex_retire_buffer: captures one record per retired instruction into a small
// FIFO so a stalled trace checker never back-pressures the core.
// Optional feature macro: IBEX_RETIRE_WDATA_EN (store RF write data per entry;
// when undefined rec_o.wdata is tied to zero and no wdata storage exists).
module ibex_retire_buffer
   import ibex_pkg::*;
#(
   parameter int unsigned Depth = 4,
   parameter int unsigned SeqW  = RetireSeqW
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            instr_done_wb_i,
   input  logic [31:0]     pc_wb_i,
   input  logic [31:0]     instr_rdata_wb_i,
   input  logic            rf_we_wb_i,
   input  logic [4:0]      rf_waddr_wb_i,
   input  logic [31:0]     rf_wdata_wb_i,
   input  logic            lsu_resp_err_i,
   output logic            rec_valid_o,
   input  logic            rec_ready_i,
   output retire_rec_t     rec_o,
   output logic            overflow_o,
   output logic [SeqW-1:0] drop_cnt_o,
   output logic [SeqW-1:0] retire_cnt_o
);

   localparam int unsigned CntW = $clog2(Depth) + 1;

`ifdef IBEX_RETIRE_WDATA_EN
   localparam int unsigned StoreW = $bits(retire_rec_t);
`else
   localparam int unsigned StoreW = $bits(retire_lite_t);
`endif

   logic [SeqW-1:0]   retire_cnt_q, retire_cnt_d;
   logic [SeqW-1:0]   drop_cnt_q, drop_cnt_d;
   logic              overflow_q, overflow_d;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CntW-1:0]   fifo_count;
   logic              pop;
   logic              accept;
   logic              push;
   logic              drop;
   logic [4:0]        rd_in;
   logic [StoreW-1:0] push_data;
   logic [StoreW-1:0] head_data;

   assign rec_valid_o  = (fifo_count != '0);
   assign overflow_o   = overflow_q;
   assign drop_cnt_o   = drop_cnt_q;
   assign retire_cnt_o = retire_cnt_q;

   // Accept a retire when there is room, or room is being made this cycle.
   always_comb begin
      pop    = rec_valid_o && rec_ready_i;
      accept = !fifo_full || pop || flush_i;
      push   = instr_done_wb_i && accept;
      drop   = instr_done_wb_i && !accept;
      rd_in  = rf_we_wb_i ? rf_waddr_wb_i : 5'd0;
   end

`ifdef IBEX_RETIRE_WDATA_EN
   retire_rec_t push_rec;

   // Form the full record; writes to x0 carry no data.
   always_comb begin
      push_rec       = '0;
      push_rec.seq   = RetireSeqW'(retire_cnt_q);
      push_rec.pc    = pc_wb_i;
      push_rec.instr = instr_rdata_wb_i;
      push_rec.rd    = rd_in;
      push_rec.wdata = (rf_we_wb_i && (rd_in != 5'd0)) ? rf_wdata_wb_i : 32'd0;
      push_rec.err   = lsu_resp_err_i;
      push_data      = push_rec;
      rec_o          = head_data;
   end
`else
   retire_lite_t push_lite;
   retire_lite_t head_lite;
   logic         unused_wdata;

   assign unused_wdata = ^rf_wdata_wb_i;

   // Form the record without write data and re-expand it with wdata tied low.
   always_comb begin
      push_lite       = '0;
      push_lite.seq   = RetireSeqW'(retire_cnt_q);
      push_lite.pc    = pc_wb_i;
      push_lite.instr = instr_rdata_wb_i;
      push_lite.rd    = rd_in;
      push_lite.err   = lsu_resp_err_i;
      push_data       = push_lite;
      head_lite       = head_data;
      rec_o           = '0;
      rec_o.seq       = head_lite.seq;
      rec_o.pc        = head_lite.pc;
      rec_o.instr     = head_lite.instr;
      rec_o.rd        = head_lite.rd;
      rec_o.err       = head_lite.err;
   end
`endif

   // Counters: every retire is counted; refused retires bump a saturating drop count.
   always_comb begin
      retire_cnt_d = instr_done_wb_i ? retire_cnt_q + SeqW'(1) : retire_cnt_q;
      drop_cnt_d   = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + SeqW'(1) : drop_cnt_q;
      overflow_d   = overflow_q | drop;
   end

   // Counter and sticky overflow registers; flush leaves them untouched.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         retire_cnt_q <= '0;
         drop_cnt_q   <= '0;
         overflow_q   <= 1'b0;
      end else begin
         retire_cnt_q <= retire_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         overflow_q   <= overflow_d;
      end
   end

   ibex_retire_fifo #(
      .Width (StoreW),
      .Depth (Depth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (push_data),
      .rdata_o (head_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   rec_stable_while_stalled: assert property (@(posedge clk_i) disable iff (rst_i)
      (rec_valid_o && !rec_ready_i && !flush_i) |=> $stable(rec_o));

   valid_matches_empty: assert property (@(posedge clk_i) disable iff (rst_i)
      rec_valid_o == !fifo_empty);

endmodule

// File: tb/tb_ibex_retire_buffer.sv
// tb_ibex_retire_buffer: directed scenarios plus randomized traffic, checked each
// cycle against a queue-based model of the retire buffer.
module tb_ibex_retire_buffer;
   import ibex_pkg::*;

   localparam int Depth = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush, done, we, err, ready;
   logic [31:0] pc, instr, wdata;
   logic [4:0]  waddr;
   logic        rec_valid, overflow;
   retire_rec_t rec;
   logic [31:0] drop_cnt, retire_cnt;

   int checks = 0;
   int failures = 0;

   retire_rec_t mq[$];
   logic [31:0] m_retire;
   logic [31:0] m_drop;
   bit          m_ovf;

`ifdef IBEX_RETIRE_WDATA_EN
   localparam bit WdataOn = 1'b1;
`else
   localparam bit WdataOn = 1'b0;
`endif

   ibex_retire_buffer #(.Depth(Depth), .SeqW(32)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .flush_i          (flush),
      .instr_done_wb_i  (done),
      .pc_wb_i          (pc),
      .instr_rdata_wb_i (instr),
      .rf_we_wb_i       (we),
      .rf_waddr_wb_i    (waddr),
      .rf_wdata_wb_i    (wdata),
      .lsu_resp_err_i   (err),
      .rec_valid_o      (rec_valid),
      .rec_ready_i      (ready),
      .rec_o            (rec),
      .overflow_o       (overflow),
      .drop_cnt_o       (drop_cnt),
      .retire_cnt_o     (retire_cnt)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [159:0] actual,
                              input logic [159:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input bit d, input logic [31:0] p, input logic [31:0] ins,
                                input bit w, input logic [4:0] a, input logic [31:0] wd,
                                input bit e, input bit rdy, input bit fl);
      done = d; pc = p; instr = ins; we = w; waddr = a; wdata = wd;
      err = e; ready = rdy; flush = fl;
   endtask

   function automatic retire_rec_t buildRec();
      retire_rec_t r;
      r       = '0;
      r.seq   = m_retire;
      r.pc    = pc;
      r.instr = instr;
      r.rd    = we ? waddr : 5'd0;
      r.wdata = (WdataOn && we && r.rd != 5'd0) ? wdata : 32'd0;
      r.err   = err;
      return r;
   endfunction

   task automatic modelUpdate();
      bit pop;
      pop = (mq.size() != 0) && ready;
      if (flush) mq.delete();
      else if (pop) void'(mq.pop_front());
      if (done) begin
         if (mq.size() < Depth) mq.push_back(buildRec());
         else begin
            if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
            m_ovf = 1'b1;
         end
         m_retire = m_retire + 1;
      end
   endtask

   task automatic compareAll();
      retire_rec_t exp;
      exp = (mq.size() != 0) ? mq[0] : '0;
      checkOutput("rec_valid", rec_valid, mq.size() != 0);
      checkOutput("rec_o", rec, exp);
      checkOutput("overflow", overflow, m_ovf);
      checkOutput("drop_cnt", drop_cnt, m_drop);
      checkOutput("retire_cnt", retire_cnt, m_retire);
   endtask

   task automatic stepCycle();
      @(posedge clk);
      modelUpdate();
      @(negedge clk);
      compareAll();
   endtask

   task automatic doReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      mq.delete();
      m_retire = 0;
      m_drop   = 0;
      m_ovf    = 1'b0;
      #1;
      compareAll();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      compareAll();
   endtask

   task automatic pushN(input int n, input int base);
      for (int k = 0; k < n; k++) begin
         applyStimulus(1, 32'h100 + 32'(4 * (base + k)), 32'h13 + 32'(k), 1, 5'(k + 1),
                       32'(k + 7), 0, 0, 0);
         stepCycle();
      end
   endtask

   initial begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Test 1: single retire with a register write
      doReset();
      applyStimulus(1, 32'h80, 32'h0050_0093, 1, 5'd1, 32'd5, 0, 0, 0);
      stepCycle();
      checkOutput("t1_valid", rec_valid, 1);
      checkOutput("t1_seq", rec.seq, 0);
      checkOutput("t1_pc", rec.pc, 32'h80);
      checkOutput("t1_instr", rec.instr, 32'h0050_0093);
      checkOutput("t1_rd", rec.rd, 1);
      checkOutput("t1_wdata", rec.wdata, WdataOn ? 5 : 0);
      checkOutput("t1_err", rec.err, 0);
      checkOutput("t1_retire", retire_cnt, 1);

      // Test 2: writes to x0 and non-writing instructions carry no rd/wdata
      doReset();
      applyStimulus(1, 32'h84, 32'h1, 1, 5'd0, 32'hDEAD, 0, 0, 0);
      stepCycle();
      applyStimulus(1, 32'h88, 32'h2, 0, 5'd7, 32'h1234, 1, 0, 0);
      stepCycle();
      checkOutput("t2_rd_x0", rec.rd, 0);
      checkOutput("t2_wd_x0", rec.wdata, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
      stepCycle();
      checkOutput("t2_seq_nowe", rec.seq, 1);
      checkOutput("t2_rd_nowe", rec.rd, 0);
      checkOutput("t2_wd_nowe", rec.wdata, 0);
      checkOutput("t2_err", rec.err, 1);

      // Test 3: overflow with a stalled consumer, then drain in order
      doReset();
      pushN(6, 0);
      checkOutput("t3_drop", drop_cnt, 2);
      checkOutput("t3_ovf", overflow, 1);
      checkOutput("t3_retire", retire_cnt, 6);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int k = 0; k < 4; k++) begin
         checkOutput("t3_drain_seq", rec.seq, k);
         stepCycle();
      end
      checkOutput("t3_empty", rec_valid, 0);
      checkOutput("t3_ovf_sticky", overflow, 1);

      // Test 4: push and pop together while full
      doReset();
      pushN(4, 0);
      applyStimulus(1, 32'h200, 32'h33, 0, 0, 0, 0, 1, 0);
      stepCycle();
      checkOutput("t4_nodrop", drop_cnt, 0);
      checkOutput("t4_ovf", overflow, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int k = 1; k <= 4; k++) begin
         checkOutput("t4_seq", rec.seq, k);
         stepCycle();
      end
      checkOutput("t4_empty", rec_valid, 0);

      // Test 5: flush with a same-cycle retire
      doReset();
      pushN(2, 0);
      applyStimulus(1, 32'h300, 32'h44, 1, 5'd3, 32'd9, 0, 1, 1);
      stepCycle();
      checkOutput("t5_valid", rec_valid, 1);
      checkOutput("t5_seq", rec.seq, 2);
      checkOutput("t5_pc", rec.pc, 32'h300);
      checkOutput("t5_retire", retire_cnt, 3);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
      stepCycle();
      checkOutput("t5_count1", rec_valid, 0);

      // Test 6: asynchronous reset mid-stream
      doReset();
      pushN(3, 0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t6_valid", rec_valid, 0);
      checkOutput("t6_retire", retire_cnt, 0);
      checkOutput("t6_drop", drop_cnt, 0);
      checkOutput("t6_ovf", overflow, 0);
      checkOutput("t6_rec", rec, 0);
      doReset();

      // Randomized traffic with occasional flushes and resets
      for (int i = 0; i < 3000; i++) begin
         if (i % 700 == 350) begin
            doReset();
         end else begin
            applyStimulus($urandom_range(0, 9) < 6, $urandom, $urandom,
                          $urandom_range(0, 1) == 1,
                          ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                          $urandom, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 9) < 4, $urandom_range(0, 31) == 0);
            stepCycle();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
